mips_regfile_sb: RTL and testbench

- Parametrised general-purpose register file for the MIPS datapath, generalising the register writeback decode to all 2^ADDR_W registers.
- Provides 2 combinational read ports with write-through bypass and 1 clocked write port.
- Write destination is selectable from the rd field, the rt field, or the link register.
- Carries a per-register busy scoreboard so decode stalls on operands whose writeback is still outstanding.

---
 rtl/mips_regfile_sb.sv | 95 +++++++++
 tb/tb_mips_regfile_sb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_sb.sv
// MIPS general-purpose register file: two combinational read ports with write-through
// bypass, one clocked write port, and a per-register busy scoreboard for decode stalls.
module mips_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       rd_instr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              stall,
    input  logic              iss_valid,
    input  logic [31:0]       iss_instr,
    input  logic [1:0]        iss_dst_sel,
    input  logic              wb_valid,
    input  logic [31:0]       wb_instr,
    input  logic [1:0]        wb_dst_sel,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    // Address 0 doubles as "no destination": register 0 can never be a target.
    function automatic logic [ADDR_W-1:0] dst_decode(input logic [31:0] instr,
                                                     input logic [1:0]  sel);
        case (sel)
            2'd0:    dst_decode = ADDR_W'(instr[15:11]);
            2'd1:    dst_decode = ADDR_W'(instr[20:16]);
            2'd2:    dst_decode = ADDR_W'(LINK_REG);
            default: dst_decode = '0;
        endcase
    endfunction

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;
    logic [ADDR_W:0]   cnt_next;

    logic [ADDR_W-1:0] rs_a, rt_a, iss_dst, wb_dst;
    logic              wb_hit, byp_rs, byp_rt;

    assign rs_a    = ADDR_W'(rd_instr[25:21]);
    assign rt_a    = ADDR_W'(rd_instr[20:16]);
    assign iss_dst = dst_decode(iss_instr, iss_dst_sel);
    assign wb_dst  = dst_decode(wb_instr, wb_dst_sel);

    // Bypass is suppressed during reset so the read ports show the cleared file.
    assign wb_hit = wb_valid && (wb_dst != '0) && !rst;
    assign byp_rs = wb_hit && (wb_dst == rs_a);
    assign byp_rt = wb_hit && (wb_dst == rt_a);

    assign rs_data = (rs_a == '0) ? '0 : (byp_rs ? wb_data : regs[rs_a]);
    assign rt_data = (rt_a == '0) ? '0 : (byp_rt ? wb_data : regs[rt_a]);

    assign stall = (busy[rs_a] && !byp_rs) || (busy[rt_a] && !byp_rt);

    // A new producer in the same cycle as a writeback keeps the register pending.
    always_comb begin
        busy_next    = busy;
        busy_next[0] = 1'b0;
        if (wb_valid && (wb_dst != '0))
            busy_next[wb_dst] = 1'b0;
        if (iss_valid && (iss_dst != '0))
            busy_next[iss_dst] = 1'b1;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREG; i++)
            cnt_next = cnt_next + (ADDR_W+1)'(busy_next[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wb_valid && (wb_dst != '0))
                regs[wb_dst] <= wb_data;
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rd_instr[31:26], rd_instr[15:0],
                           iss_instr[31:21], iss_instr[10:0],
                           wb_instr[31:21], wb_instr[10:0]};

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed self-checking bench for mips_regfile_sb: reset, bypass, register zero,
// scoreboard stall/clear, link-register set/clear collision and mid-operation reset.
module tb_mips_regfile_sb;

    logic        clk;
    logic        rst;
    logic [31:0] rd_instr;
    logic [31:0] rs_data, rt_data;
    logic        stall;
    logic        iss_valid;
    logic [31:0] iss_instr;
    logic [1:0]  iss_dst_sel;
    logic        wb_valid;
    logic [31:0] wb_instr;
    logic [1:0]  wb_dst_sel;
    logic [31:0] wb_data;
    logic [5:0]  busy_cnt;

    int checks   = 0;
    int failures = 0;

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31)) dut (
        .clk(clk), .rst(rst), .rd_instr(rd_instr),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
        .iss_valid(iss_valid), .iss_instr(iss_instr), .iss_dst_sel(iss_dst_sel),
        .wb_valid(wb_valid), .wb_instr(wb_instr), .wb_dst_sel(wb_dst_sel),
        .wb_data(wb_data), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int rs, input int rt, input int rd);
        logic [4:0] a, b, c;
        a = 5'(rs); b = 5'(rt); c = 5'(rd);
        mk = {6'h00, a, b, c, 11'h000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_instr = '0; iss_dst_sel = 2'd3;
        wb_valid  = 1'b0; wb_instr  = '0; wb_dst_sel  = 2'd3; wb_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        rd_instr = mk(8, 0, 0);
        wb_valid = 1'b1; wb_dst_sel = 2'd0; wb_instr = mk(0, 0, 8); wb_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin
            failures++; $display("FAIL reset_rs_during got=%h exp=%h", rs_data, 32'h0);
        end
        tick(); tick();
        checks++;
        if (busy_cnt !== 6'd0 || stall !== 1'b0) begin
            failures++; $display("FAIL reset_state got cnt=%0d stall=%b exp cnt=0 stall=0", busy_cnt, stall);
        end
        idle();
        #2 rst = 1'b0;
        tick();
        checks++;
        if (rs_data !== 32'h0 || busy_cnt !== 6'd0) begin
            failures++; $display("FAIL reset_release got rs=%h cnt=%0d exp rs=0 cnt=0", rs_data, busy_cnt);
        end
    endtask

    task automatic test_bypass();
        rd_instr = mk(9, 9, 0);
        wb_valid = 1'b1; wb_dst_sel = 2'd0; wb_instr = mk(0, 0, 9); wb_data = 32'h12345678;
        #1;
        checks++;
        if (rs_data !== 32'h12345678 || rt_data !== 32'h12345678) begin
            failures++; $display("FAIL bypass got rs=%h rt=%h exp=12345678", rs_data, rt_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs_data !== 32'h12345678) begin
            failures++; $display("FAIL write_read got=%h exp=12345678", rs_data);
        end
    endtask

    task automatic test_reg_zero();
        rd_instr = mk(0, 0, 0);
        wb_valid = 1'b1; wb_dst_sel = 2'd1; wb_instr = mk(0, 0, 0); wb_data = 32'hFFFFFFFF;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin
            failures++; $display("FAIL zero_bypass got=%h exp=0", rs_data);
        end
        tick();
        idle();
        iss_valid = 1'b1; iss_dst_sel = 2'd0; iss_instr = mk(0, 0, 0);
        tick();
        iss_dst_sel = 2'd3; iss_instr = mk(0, 0, 5);
        tick();
        idle();
        #1;
        checks++;
        if (rs_data !== 32'h0 || busy_cnt !== 6'd0 || stall !== 1'b0) begin
            failures++; $display("FAIL zero_reg got rs=%h cnt=%0d stall=%b exp rs=0 cnt=0 stall=0", rs_data, busy_cnt, stall);
        end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_dst_sel = 2'd1; iss_instr = mk(0, 16, 0);
        tick();
        idle();
        rd_instr = mk(0, 16, 0);
        #1;
        checks++;
        if (busy_cnt !== 6'd1 || stall !== 1'b1) begin
            failures++; $display("FAIL sb_rt_busy got cnt=%0d stall=%b exp cnt=1 stall=1", busy_cnt, stall);
        end
        rd_instr = mk(16, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL sb_rs_busy got stall=%b exp=1", stall);
        end
        rd_instr = mk(3, 4, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL sb_unrelated got stall=%b exp=0", stall);
        end
        rd_instr = mk(0, 16, 0);
        wb_valid = 1'b1; wb_dst_sel = 2'd0; wb_instr = mk(0, 0, 16); wb_data = 32'h55;
        #1;
        checks++;
        if (stall !== 1'b0 || rt_data !== 32'h55) begin
            failures++; $display("FAIL sb_wb_bypass got stall=%b rt=%h exp stall=0 rt=55", stall, rt_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || stall !== 1'b0 || rt_data !== 32'h55) begin
            failures++; $display("FAIL sb_cleared got cnt=%0d stall=%b rt=%h exp cnt=0 stall=0 rt=55", busy_cnt, stall, rt_data);
        end
    endtask

    task automatic test_link();
        iss_valid = 1'b1; iss_dst_sel = 2'd2; iss_instr = mk(0, 7, 7);
        tick();
        checks++;
        if (busy_cnt !== 6'd1) begin
            failures++; $display("FAIL link_set got cnt=%0d exp=1", busy_cnt);
        end
        wb_valid = 1'b1; wb_dst_sel = 2'd2; wb_instr = mk(0, 0, 0); wb_data = 32'hA0;
        tick();
        idle();
        rd_instr = mk(31, 0, 0);
        #1;
        checks++;
        if (busy_cnt !== 6'd1 || stall !== 1'b1 || rs_data !== 32'hA0) begin
            failures++; $display("FAIL link_collide got cnt=%0d stall=%b rs=%h exp cnt=1 stall=1 rs=a0", busy_cnt, stall, rs_data);
        end
        wb_valid = 1'b1; wb_dst_sel = 2'd0; wb_instr = mk(0, 0, 31); wb_data = 32'hB0;
        tick();
        idle();
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || stall !== 1'b0 || rs_data !== 32'hB0) begin
            failures++; $display("FAIL link_clear got cnt=%0d stall=%b rs=%h exp cnt=0 stall=0 rs=b0", busy_cnt, stall, rs_data);
        end
    endtask

    task automatic test_reset_mid();
        iss_valid = 1'b1; iss_dst_sel = 2'd0;
        iss_instr = mk(0, 0, 8);  tick();
        iss_instr = mk(0, 0, 9);  tick();
        iss_instr = mk(0, 0, 10); tick();
        idle();
        rd_instr = mk(8, 9, 0);
        #1;
        checks++;
        if (busy_cnt !== 6'd3 || stall !== 1'b1) begin
            failures++; $display("FAIL mid_busy got cnt=%0d stall=%b exp cnt=3 stall=1", busy_cnt, stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || stall !== 1'b0 || rt_data !== 32'h0) begin
            failures++; $display("FAIL mid_reset got cnt=%0d stall=%b rt=%h exp cnt=0 stall=0 rt=0", busy_cnt, stall, rt_data);
        end
        wb_valid = 1'b1; wb_dst_sel = 2'd0; wb_instr = mk(0, 0, 10); wb_data = 32'h77;
        iss_valid = 1'b1; iss_dst_sel = 2'd0; iss_instr = mk(0, 0, 12);
        tick();
        idle();
        rst = 1'b0;
        rd_instr = mk(10, 31, 0);
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0 || busy_cnt !== 6'd0) begin
            failures++; $display("FAIL mid_discard got rs=%h rt=%h cnt=%0d exp rs=0 rt=0 cnt=0", rs_data, rt_data, busy_cnt);
        end
        iss_valid = 1'b1; iss_dst_sel = 2'd1; iss_instr = mk(0, 12, 0);
        tick();
        idle();
        rd_instr = mk(0, 12, 0);
        #1;
        checks++;
        if (busy_cnt !== 6'd1 || stall !== 1'b1) begin
            failures++; $display("FAIL mid_first_edge got cnt=%0d stall=%b exp cnt=1 stall=1", busy_cnt, stall);
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_instr = '0;
        idle();
        test_reset();
        test_bypass();
        test_reg_zero();
        test_scoreboard();
        test_link();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
